// File: rtl/wb_queue_pkg.sv
// wb_queue_pkg: shared widths and the queued write-back entry type.
package wb_queue_pkg;
   localparam int XLEN = 32;
   localparam int AW = 5;
   localparam logic [AW-1:0] REG_ZERO = '0;
   typedef struct packed {
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_queue_if.sv
// wb_queue_if: result input, register-file write port and forwarding lookups of the write-back queue.
interface wb_queue_if
   import wb_queue_pkg::*;
#(
   parameter int DEPTH = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic [AW-1:0]           in_rd;
   logic [XLEN-1:0]         in_data;
   logic                    rf_enable;
   logic [AW-1:0]           rf_rd;
   logic [XLEN-1:0]         rf_write_data;
   logic [AW-1:0]           lookup_rs1;
   logic [AW-1:0]           lookup_rs2;
   logic                    fwd1_hit;
   logic [XLEN-1:0]         fwd1_data;
   logic                    fwd2_hit;
   logic [XLEN-1:0]         fwd2_data;
   logic [$clog2(DEPTH):0]  count;
   modport master (
      output in_valid, in_rd, in_data, lookup_rs1, lookup_rs2,
      input  in_ready, rf_enable, rf_rd, rf_write_data,
      input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
   );
   modport slave (
      input  in_valid, in_rd, in_data, lookup_rs1, lookup_rs2,
      output in_ready, rf_enable, rf_rd, rf_write_data,
      output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
   );
endinterface

// File: rtl/wb_queue_fwd_match.sv
// wb_queue_fwd_match: youngest-wins search of the queue (oldest first from rd_ptr) over the output stage.
module wb_queue_fwd_match
   import wb_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
)(
   input  wb_entry_t        i_entries [DEPTH],
   input  logic [DEPTH-1:0] i_valid,
   input  logic [PW-1:0]    i_rd_ptr,
   input  logic [AW-1:0]    i_lookup,
   input  logic             i_out_en,
   input  logic [AW-1:0]    i_out_rd,
   input  logic [XLEN-1:0]  i_out_data,
   output logic             o_hit,
   output logic [XLEN-1:0]  o_data
);
   logic [PW-1:0] w_idx;

   always_comb begin
      w_idx = '0;
      o_hit = i_out_en && (i_out_rd == i_lookup);
      o_data = o_hit ? i_out_data : '0;
      // later (younger) matches overwrite earlier ones
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = i_rd_ptr + PW'(k);
         if (i_valid[w_idx] && (i_entries[w_idx].rd == i_lookup)) begin
            o_hit = 1'b1;
            o_data = i_entries[w_idx].data;
         end
      end
      if (i_lookup == REG_ZERO) begin
         o_hit = 1'b0;
         o_data = '0;
      end
   end
endmodule

// File: rtl/wb_queue.sv
// wb_queue: in-order write-back FIFO draining one result per cycle into a registered register-file port,
// with two forwarding lookups over queued and in-flight results.
module wb_queue
   import wb_queue_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic       clk,
   input  logic       reset,
   wb_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t        r_mem [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] w_valid_nxt;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_rf_enable;
   logic [AW-1:0]    r_rf_rd;
   logic [XLEN-1:0]  r_rf_data;
   logic             w_ready;
   logic             w_push;
   logic             w_pop;
   logic             w_fwd1_hit;
   logic             w_fwd2_hit;
   logic [XLEN-1:0]  w_fwd1_data;
   logic [XLEN-1:0]  w_fwd2_data;

   assign w_ready = (r_count != CW'(DEPTH));
   // x0 results complete the handshake but are dropped
   assign w_push = bus.in_valid && w_ready && (bus.in_rd != REG_ZERO);
   assign w_pop = (r_count != '0);

   always_comb begin
      w_valid_nxt = r_valid;
      if (w_pop) w_valid_nxt[r_rd_ptr] = 1'b0;
      if (w_push) w_valid_nxt[r_wr_ptr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= '{rd: bus.in_rd, data: bus.in_data};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count <= '0;
         r_rf_enable <= 1'b0;
         r_rf_rd <= '0;
         r_rf_data <= '0;
      end else begin
         r_valid <= w_valid_nxt;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         r_rf_enable <= w_pop;
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_rf_rd <= r_mem[r_rd_ptr].rd;
            r_rf_data <= r_mem[r_rd_ptr].data;
         end
      end
   end

   wb_queue_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
      .i_entries(r_mem), .i_valid(r_valid), .i_rd_ptr(r_rd_ptr), .i_lookup(bus.lookup_rs1),
      .i_out_en(r_rf_enable), .i_out_rd(r_rf_rd), .i_out_data(r_rf_data),
      .o_hit(w_fwd1_hit), .o_data(w_fwd1_data)
   );

   wb_queue_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
      .i_entries(r_mem), .i_valid(r_valid), .i_rd_ptr(r_rd_ptr), .i_lookup(bus.lookup_rs2),
      .i_out_en(r_rf_enable), .i_out_rd(r_rf_rd), .i_out_data(r_rf_data),
      .o_hit(w_fwd2_hit), .o_data(w_fwd2_data)
   );

   assign bus.in_ready = w_ready;
   assign bus.rf_enable = r_rf_enable;
   assign bus.rf_rd = r_rf_rd;
   assign bus.rf_write_data = r_rf_data;
   assign bus.count = r_count;
   assign bus.fwd1_hit = w_fwd1_hit;
   assign bus.fwd1_data = w_fwd1_data;
   assign bus.fwd2_hit = w_fwd2_hit;
   assign bus.fwd2_data = w_fwd2_data;
endmodule
